// File: rtl/gs_cpld_glue.sv
// Bus-glue CPLD for the General Sound board.
// Decodes Z80 memory and IO cycles, pages ROM/RAM, and buffers data between d and rd.
// Also drives FPGA configuration (config_n), holds the cold-reset flag and selects clkout.
// After the FPGA reports init_done, the memory controls float and the FPGA's RAM selects
// pass through.
module gs_cpld_glue #(
    parameter int unsigned WRES_CYC = 4
) (
    input  logic       clkin,
    input  logic       coldres_n,

    input  logic       clk20in,
    input  logic       clk24in,
    input  logic       clksel0,
    input  logic       clksel1,
    output logic       clkout,

    output logic       warmres_n,

    output logic       config_n,
    input  logic       status_n,
    input  logic       conf_done,
    input  logic       init_done,
    output logic       cs,

    input  logic       mreq_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    inout  logic [7:0] d,
    input  logic       a6,
    input  logic       a7,
    input  logic       a10,
    input  logic       a11,
    input  logic       a12,
    input  logic       a13,
    input  logic       a14,
    input  logic       a15,

    output logic       memoe_n,
    output logic       memwe_n,
    output logic       romcs_n,
    output logic       mema14,
    output logic       mema15,
    output logic       mema19,

    input  logic       in_ramcs0_n,
    input  logic       in_ramcs1_n,
    input  logic       in_ramcs2_n,
    input  logic       in_ramcs3_n,
    output logic       out_ramcs0_n,
    output logic       out_ramcs1_n,

    inout  logic [7:0] rd,
    output logic       ra6,
    output logic       ra7,
    output logic       ra10,
    output logic       ra11,
    output logic       ra12,
    output logic       ra13
);

    localparam int unsigned CNT_W = $clog2(WRES_CYC + 1);
    localparam logic [CNT_W-1:0] WRES_MAX = CNT_W'(WRES_CYC);

    // Control registers
    logic             cfg_bit_q;
    logic             mode_q;
    logic             half_q;
    logic             cold_q;
    logic             offline_q;
    logic             init_s1_q;
    logic [CNT_W-1:0] wres_cnt_q;
    logic [1:0]       clksel_q;

    // IO decode
    logic port80;
    logic port40;
    logic io_wr;
    logic io_rd;

    // Online memory decode
    logic rom_sel;
    logic ram_sel;
    logic mema14_on;
    logic mema15_on;

    // Resolved RAM selects and data-path enables
    logic       ramcs0_int;
    logic       ramcs1_int;
    logic       mema19_int;
    logic       io_oe;
    logic [7:0] io_dout;
    logic       mem_rd_oe;
    logic       mem_wr_oe;

    // Buffered address lines are pure wires
    assign ra6  = a6;
    assign ra7  = a7;
    assign ra10 = a10;
    assign ra11 = a11;
    assign ra12 = a12;
    assign ra13 = a13;

    assign port80 = a7 & ~a6;
    assign port40 = ~a7 & a6;
    assign io_wr  = ~iorq_n & ~wr_n;
    assign io_rd  = ~iorq_n & ~rd_n;

    // IO-written registers and the cold flag; the cold flag only clears on reset
    always_ff @(posedge clkin) begin
        if (!coldres_n) begin
            cfg_bit_q <= 1'b0;
            mode_q    <= 1'b0;
            half_q    <= 1'b0;
            cold_q    <= 1'b0;
        end else if (io_wr) begin
            if (port80) begin
                cfg_bit_q <= d[0];
                if (d[7]) begin
                    cold_q <= 1'b1;
                end
            end
            if (port40) begin
                mode_q <= d[7];
                half_q <= d[0];
            end
        end
    end

    // Warm reset stretch: counts up to WRES_CYC after reset, held low until it gets there
    always_ff @(posedge clkin) begin
        if (!coldres_n) begin
            wres_cnt_q <= '0;
        end else if (wres_cnt_q < WRES_MAX) begin
            wres_cnt_q <= wres_cnt_q + 1'b1;
        end
    end

    // Offline detect: two consecutive high samples of init_done latch offline until reset
    always_ff @(posedge clkin) begin
        if (!coldres_n) begin
            init_s1_q <= 1'b0;
            offline_q <= 1'b0;
        end else begin
            init_s1_q <= init_done;
            if (init_done && init_s1_q) begin
                offline_q <= 1'b1;
            end
        end
    end

    // Clock select register; the selected sources are never used as register clocks
    always_ff @(posedge clkin) begin
        if (!coldres_n) begin
            clksel_q <= 2'b00;
        end else begin
            clksel_q <= {clksel1, clksel0};
        end
    end

    assign clkout = clksel_q[1] ? clkin : (clksel_q[0] ? clk24in : clk20in);

    assign warmres_n = (wres_cnt_q < WRES_MAX) ? 1'b0 : 1'bz;
    assign config_n  = cfg_bit_q ? 1'bz : 1'b0;

    // Online memory map: 0000-3FFF ROM, 4000-7FFF RAM, 8000-FFFF paged ROM or RAM
    always_comb begin
        rom_sel   = 1'b0;
        ram_sel   = 1'b0;
        mema14_on = 1'b0;
        mema15_on = 1'b0;
        if (!a15) begin
            rom_sel = ~a14;
            ram_sel = a14;
        end else begin
            mema15_on = half_q;
            mema14_on = a14;
            rom_sel   = ~mode_q;
            ram_sel   = mode_q;
        end
    end

    // RAM select source: own decode while online, FPGA selects once offline
    always_comb begin
        ramcs0_int = ~ram_sel;
        ramcs1_int = 1'b1;
        mema19_int = 1'b0;
        if (offline_q) begin
            ramcs0_int = in_ramcs0_n & in_ramcs1_n;
            ramcs1_int = in_ramcs2_n & in_ramcs3_n;
            mema19_int = ~(in_ramcs1_n & in_ramcs3_n);
        end
    end

    assign out_ramcs0_n = ramcs0_int;
    assign out_ramcs1_n = ramcs1_int;
    assign mema19       = mema19_int;

    // Memory controls float once the FPGA owns the bus
    assign memoe_n = offline_q ? 1'bz : (mreq_n | rd_n);
    assign memwe_n = offline_q ? 1'bz : (mreq_n | wr_n);
    assign romcs_n = offline_q ? 1'bz : ~rom_sel;
    assign mema14  = offline_q ? 1'bz : mema14_on;
    assign mema15  = offline_q ? 1'bz : mema15_on;
    assign cs      = offline_q ? 1'bz : (a7 & a6);

    // Data-path enables: IO readback onto d, RAM buffer in either direction; ROM never buffered
    always_comb begin
        io_oe     = 1'b0;
        io_dout   = 8'h00;
        mem_rd_oe = 1'b0;
        mem_wr_oe = 1'b0;
        if (io_rd) begin
            if (port80) begin
                io_oe   = 1'b1;
                io_dout = {status_n, 6'b000000, conf_done};
            end else if (port40) begin
                io_oe   = 1'b1;
                io_dout = {cold_q, 7'b0000000};
            end
        end
        if (!mreq_n && (!ramcs0_int || !ramcs1_int)) begin
            if (!wr_n) begin
                mem_wr_oe = 1'b1;
            end else if (!rd_n) begin
                mem_rd_oe = 1'b1;
            end
        end
    end

    assign d  = io_oe ? io_dout : (mem_rd_oe ? rd : 8'hzz);
    assign rd = mem_wr_oe ? d : 8'hzz;

endmodule

// File: tb/tb_gs_cpld_glue.sv
// Directed self-checking bench for gs_cpld_glue.
module tb_gs_cpld_glue;

    logic clkin = 1'b0;
    logic clk20in = 1'b0;
    logic clk24in = 1'b0;
    logic coldres_n;
    logic clksel0, clksel1;
    logic conf_done, init_done;
    logic mreq_n, iorq_n, rd_n, wr_n;
    logic a6, a7, a10, a11, a12, a13, a14, a15;
    logic in_ramcs0_n, in_ramcs1_n, in_ramcs2_n, in_ramcs3_n;

    wire clkout, warmres_n, config_n, status_n, cs;
    wire memoe_n, memwe_n, romcs_n, mema14, mema15, mema19;
    wire out_ramcs0_n, out_ramcs1_n;
    wire ra6, ra7, ra10, ra11, ra12, ra13;
    wire [7:0] d;
    wire [7:0] rd;

    // Board pulls: open-drain and low-active lines pulled up, active-high lines pulled down
    pullup   (warmres_n);
    pullup   (config_n);
    pullup   (memoe_n);
    pullup   (memwe_n);
    pullup   (romcs_n);
    pulldown (mema14);
    pulldown (mema15);
    pulldown (cs);

    // FPGA model: status_n follows nCONFIG
    assign status_n = config_n;

    logic       d_oe = 1'b0;
    logic [7:0] d_val = 8'h00;
    logic       rd_oe = 1'b0;
    logic [7:0] rd_val = 8'h00;
    assign d  = d_oe ? d_val : 8'hzz;
    assign rd = rd_oe ? rd_val : 8'hzz;

    always #5 clkin = ~clkin;
    always #7 clk20in = ~clk20in;
    always #6 clk24in = ~clk24in;

    gs_cpld_glue #(.WRES_CYC(4)) dut (
        .clkin(clkin), .coldres_n(coldres_n),
        .clk20in(clk20in), .clk24in(clk24in), .clksel0(clksel0), .clksel1(clksel1),
        .clkout(clkout), .warmres_n(warmres_n),
        .config_n(config_n), .status_n(status_n), .conf_done(conf_done),
        .init_done(init_done), .cs(cs),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .d(d),
        .a6(a6), .a7(a7), .a10(a10), .a11(a11), .a12(a12), .a13(a13), .a14(a14), .a15(a15),
        .memoe_n(memoe_n), .memwe_n(memwe_n), .romcs_n(romcs_n),
        .mema14(mema14), .mema15(mema15), .mema19(mema19),
        .in_ramcs0_n(in_ramcs0_n), .in_ramcs1_n(in_ramcs1_n),
        .in_ramcs2_n(in_ramcs2_n), .in_ramcs3_n(in_ramcs3_n),
        .out_ramcs0_n(out_ramcs0_n), .out_ramcs1_n(out_ramcs1_n),
        .rd(rd), .ra6(ra6), .ra7(ra7), .ra10(ra10), .ra11(ra11), .ra12(ra12), .ra13(ra13)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Online-only lines must stay constant
    logic mon_en = 1'b0;
    logic glitch_seen = 1'b0;
    always @(negedge clkin) begin
        if (mon_en && (mema19 !== 1'b0 || out_ramcs1_n !== 1'b1)) glitch_seen = 1'b1;
    end

    task automatic set_addr(input logic [15:0] addr);
        {a15, a14, a13, a12, a11, a10} = addr[15:10];
        {a7, a6} = addr[7:6];
    endtask

    task automatic idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        d_oe = 1'b0; rd_oe = 1'b0;
    endtask

    task automatic io_wr(input logic [7:0] port, input logic [7:0] val);
        @(negedge clkin);
        set_addr({8'h00, port});
        d_val = val; d_oe = 1'b1;
        iorq_n = 1'b0; wr_n = 1'b0;
        @(posedge clkin);
        #1 idle();
    endtask

    task automatic io_rd(input logic [7:0] port, output logic [7:0] val);
        @(negedge clkin);
        set_addr({8'h00, port});
        iorq_n = 1'b0; rd_n = 1'b0;
        #1 val = d;
        idle();
    endtask

    // Leaves the memory cycle asserted so the caller can inspect outputs
    task automatic mem_start(input logic [15:0] addr, input logic wr, input logic [7:0] val);
        @(negedge clkin);
        set_addr(addr);
        mreq_n = 1'b0;
        if (wr) begin
            wr_n = 1'b0; d_val = val; d_oe = 1'b1;
        end else begin
            rd_n = 1'b0;
        end
        #1;
    endtask

    logic [7:0] v;

    initial begin
        coldres_n = 1'b0;
        clksel0 = 1'b0; clksel1 = 1'b0;
        conf_done = 1'b0; init_done = 1'b0;
        in_ramcs0_n = 1'b1; in_ramcs1_n = 1'b1; in_ramcs2_n = 1'b1; in_ramcs3_n = 1'b1;
        set_addr(16'h0000);
        idle();

        // Reset and warm-reset stretch
        repeat (3) @(posedge clkin);
        #1;
        check("warm_in_rst", {7'd0, warmres_n}, 8'h00);
        check("cfgn_in_rst", {7'd0, config_n}, 8'h00);
        @(negedge clkin) coldres_n = 1'b1;
        repeat (3) @(posedge clkin);
        #1 check("warm_stretch", {7'd0, warmres_n}, 8'h00);
        @(posedge clkin);
        #1 check("warm_release", {7'd0, warmres_n}, 8'h01);
        mon_en = 1'b1;

        // Configuration bit and status readback
        io_rd(8'h80, v); check("p80_rst", v, 8'h00);
        io_wr(8'h80, 8'h01);
        check("cfgn_z", {7'd0, config_n}, 8'h01);
        io_rd(8'h80, v); check("p80_cfg1", v, 8'h80);
        io_wr(8'h80, 8'h00);
        io_rd(8'h80, v); check("p80_cfg0", v, 8'h00);

        // Cold flag sets and never clears by writing
        io_rd(8'h40, v); check("cold_rst", v, 8'h00);
        io_wr(8'h80, 8'h81);
        io_rd(8'h40, v); check("cold_set", v, 8'h80);
        io_wr(8'h80, 8'h01);
        io_rd(8'h40, v); check("cold_sticky", v, 8'h80);

        // FPGA chip select
        for (int i = 0; i < 4; i++) begin
            @(negedge clkin);
            {a7, a6} = 2'(i);
            #1 check($sformatf("cs_%0d", i), {7'd0, cs}, (i == 3) ? 8'h01 : 8'h00);
        end

        // conf_done readback (cfg_bit is 1 here, so status_n reads 1)
        conf_done = 1'b1;
        io_rd(8'h80, v); check("conf_done1", v, 8'h81);
        conf_done = 1'b0;
        io_rd(8'h80, v); check("conf_done0", v, 8'h80);

        // ROM write in low page
        mem_start(16'h0F23, 1'b1, 8'h55);
        check("rom_lo_cs", {7'd0, romcs_n}, 8'h00);
        check("rom_lo_ram", {7'd0, out_ramcs0_n}, 8'h01);
        check("rom_lo_page", {6'd0, mema15, mema14}, 8'h00);
        check("rom_lo_we", {6'd0, memoe_n, memwe_n}, 8'h02);
        idle();

        // ROM paged at C000 with half=1
        io_wr(8'h40, 8'h01);
        mem_start(16'hC000, 1'b0, 8'h00);
        check("rom_hi_cs", {7'd0, romcs_n}, 8'h00);
        check("rom_hi_page", {6'd0, mema15, mema14}, 8'h03);
        check("rom_hi_oe", {6'd0, memoe_n, memwe_n}, 8'h01);
        idle();

        // RAM write at 7FFF passes data to rd
        mem_start(16'h7FFF, 1'b1, 8'h33);
        check("ram_wr_cs", {6'd0, romcs_n, out_ramcs0_n}, 8'h02);
        check("ram_wr_rd", rd, 8'h33);
        check("ram_wr_page", {6'd0, mema15, mema14}, 8'h00);
        idle();

        // RAM read at 4000 passes rd to d
        rd_val = 8'hA5; rd_oe = 1'b1;
        mem_start(16'h4000, 1'b0, 8'h00);
        check("ram_rd_d", d, 8'hA5);
        idle();

        // RAM paged at 8000 with mode=1 half=1
        io_wr(8'h40, 8'h81);
        mem_start(16'h8000, 1'b0, 8'h00);
        check("ram_hi_cs", {6'd0, romcs_n, out_ramcs0_n}, 8'h02);
        check("ram_hi_page", {6'd0, mema15, mema14}, 8'h02);
        idle();

        // Clock select
        for (int s = 0; s < 3; s++) begin
            @(negedge clkin);
            {clksel1, clksel0} = 2'(s);
            @(posedge clkin);
            #1 check($sformatf("clk_sel%0d_h", s), {7'd0, clkout},
                     {7'd0, (s == 2) ? clkin : ((s == 1) ? clk24in : clk20in)});
            @(negedge clkin);
            #1 check($sformatf("clk_sel%0d_l", s), {7'd0, clkout},
                     {7'd0, (s == 2) ? clkin : ((s == 1) ? clk24in : clk20in)});
        end

        // Going offline: set up a cycle where every online control is active
        io_wr(8'h40, 8'h01);
        @(negedge clkin);
        set_addr(16'hC0C0);
        mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        #1 check("pre_off", {2'd0, memoe_n, memwe_n, romcs_n, mema15, mema14, cs}, 8'h07);
        mon_en = 1'b0;
        check("no_glitch", {7'd0, glitch_seen}, 8'h00);
        init_done = 1'b1;
        @(posedge clkin);
        #1 check("off_1st", {7'd0, memoe_n}, 8'h00);
        @(posedge clkin);
        #1 check("off_2nd", {2'd0, memoe_n, memwe_n, romcs_n, mema15, mema14, cs}, 8'h38);

        // FPGA selects pass through and the buffer still runs from the strobes
        @(negedge clkin);
        rd_n = 1'b1;
        in_ramcs1_n = 1'b0;
        d_val = 8'h3C; d_oe = 1'b1;
        #1 check("off_cs1", {5'd0, mema19, out_ramcs1_n, out_ramcs0_n}, 8'h06);
        check("off_buf", rd, 8'h3C);
        @(negedge clkin);
        in_ramcs1_n = 1'b1; in_ramcs2_n = 1'b0;
        #1 check("off_cs2", {5'd0, mema19, out_ramcs1_n, out_ramcs0_n}, 8'h01);
        in_ramcs2_n = 1'b1;
        d_oe = 1'b0; wr_n = 1'b1; rd_n = 1'b0;
        init_done = 1'b0;
        repeat (3) @(posedge clkin);
        #1 check("off_sticky", {7'd0, memoe_n}, 8'h01);

        // Reset brings the controls back online and clears the cold flag
        @(negedge clkin) coldres_n = 1'b0;
        @(posedge clkin);
        #1 check("rst_online", {7'd0, memoe_n}, 8'h00);
        idle();
        @(negedge clkin) coldres_n = 1'b1;
        io_rd(8'h40, v); check("cold_clr", v, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
